// File: rtl/led_pio_sequencer.sv
// led_pio_sequencer
// Avalon-MM block that alternates two LED patterns on the 8-bit LED PIO s1
// slave. Software programs PAT_A, PAT_B and PERIOD through a four-word slave
// register file. The block then issues single-cycle master writes to the PIO,
// either free-running or one-shot (A, B, then all-off).
//
// Ports
//   clk, reset_n            system clock, asynchronous active-low reset
//   address/chipselect/
//   write_n/writedata       slave write port (write = chipselect & !write_n)
//   readdata                slave read data, combinational from address
//   pio_address             master address to the PIO, always 0
//   pio_chipselect/
//   pio_write_n             master write strobe, exactly one cycle wide
//   pio_writedata           master write data {zeros, pattern}
//   irq                     (only with LED_SEQ_IRQ_EN) DONE & IRQ_EN
//
// Register map
//   0 CTRL    bit0 RUN, bit1 ONESHOT (R/W); read-only bit2 PHASE, bit3 PEND
//             with LED_SEQ_IRQ_EN: bit4 IRQ_EN (R/W), bit5 DONE (read;
//             writing 1 clears it)
//   1 PAT_A   2 PAT_B   3 PERIOD (clk cycles per phase, 0 = hold)
//
// Optional feature macro: LED_SEQ_IRQ_EN
module led_pio_sequencer #(
  parameter int LED_W    = 8,
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW_A = 2'd1,
    ST_SHOW_B = 2'd2
  } state_t;

  state_t              state_r, state_nx_s;
  logic [PERIOD_W-1:0] counter_r, counter_nx_s, period_r;
  logic [LED_W-1:0]    pat_a_r, pat_b_r, pat_a_nx_s, pat_b_nx_s, strobe_data_s;
  logic                oneshot_r, strobe_s, done_set_s;
  logic                wr_s, wr_ctrl_s, wr_pat_a_s, wr_pat_b_s, wr_period_s;
  logic                running_s, expiry_s, start_s, stop_s, refresh_s;
  logic                pio_chipselect_r, pio_write_n_r;
  logic [31:0]         pio_writedata_r;
  logic                unused_s;

  assign wr_s        = chipselect & ~write_n;
  assign wr_ctrl_s   = wr_s & (address == 2'd0);
  assign wr_pat_a_s  = wr_s & (address == 2'd1);
  assign wr_pat_b_s  = wr_s & (address == 2'd2);
  assign wr_period_s = wr_s & (address == 2'd3);

  // Pattern values as they will be after this cycle; an expiry that lands on
  // a pattern write must show the freshly written value.
  assign pat_a_nx_s = wr_pat_a_s ? writedata[LED_W-1:0] : pat_a_r;
  assign pat_b_nx_s = wr_pat_b_s ? writedata[LED_W-1:0] : pat_b_r;

  assign running_s = (state_r != ST_IDLE);
  // ">=" rather than "==": a PERIOD shrunk below the current count expires
  // on the very next comparison instead of wrapping the counter.
  assign expiry_s  = running_s && (period_r != '0) &&
                     (counter_r >= (period_r - PERIOD_W'(1'b1)));
  assign start_s   = wr_ctrl_s & ~running_s & writedata[0];
  assign stop_s    = wr_ctrl_s & running_s & ~writedata[0];
  assign refresh_s = ((state_r == ST_SHOW_A) && wr_pat_a_s) ||
                     ((state_r == ST_SHOW_B) && wr_pat_b_s);

  // Next-state, phase counter and strobe request; stop beats expiry, expiry
  // beats refresh.
  always_comb begin
    state_nx_s    = state_r;
    counter_nx_s  = counter_r;
    strobe_s      = 1'b0;
    strobe_data_s = '0;
    done_set_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        counter_nx_s = '0;
        if (start_s) begin
          state_nx_s    = ST_SHOW_A;
          strobe_s      = 1'b1;
          strobe_data_s = pat_a_r;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHOW_A, ST_SHOW_B: begin
        if (stop_s) begin
          state_nx_s    = ST_IDLE;
          counter_nx_s  = '0;
          strobe_s      = 1'b1;
          strobe_data_s = '0;
        end else if (expiry_s) begin
          counter_nx_s = '0;
          strobe_s     = 1'b1;
          if (state_r == ST_SHOW_A) begin
            state_nx_s    = ST_SHOW_B;
            strobe_data_s = pat_b_nx_s;
          end else begin
            done_set_s = 1'b1;
            if (oneshot_r) begin
              state_nx_s    = ST_IDLE;
              strobe_data_s = '0;
            end else begin
              state_nx_s    = ST_SHOW_A;
              strobe_data_s = pat_a_nx_s;
            end
          end
        end else begin
          if (period_r == '0) begin
            counter_nx_s = '0;
          end else begin
            counter_nx_s = counter_r + PERIOD_W'(1'b1);
          end
          if (refresh_s) begin
            strobe_s      = 1'b1;
            strobe_data_s = writedata[LED_W-1:0];
          end else begin
            strobe_s = 1'b0;
          end
        end
      end
      default: begin
        state_nx_s   = ST_IDLE;
        counter_nx_s = '0;
      end
    endcase
  end

  // FSM state and phase counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      counter_r <= '0;
    end else begin
      state_r   <= state_nx_s;
      counter_r <= counter_nx_s;
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oneshot_r <= 1'b0;
      pat_a_r   <= '0;
      pat_b_r   <= '0;
      period_r  <= '0;
    end else begin
      pat_a_r <= pat_a_nx_s;
      pat_b_r <= pat_b_nx_s;
      if (wr_ctrl_s) begin
        oneshot_r <= writedata[1];
      end
      if (wr_period_s) begin
        period_r <= writedata[PERIOD_W-1:0];
      end
    end
  end

  // Registered master write port; data holds between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_chipselect_r <= 1'b0;
      pio_write_n_r    <= 1'b1;
      pio_writedata_r  <= 32'd0;
    end else begin
      pio_chipselect_r <= strobe_s;
      pio_write_n_r    <= ~strobe_s;
      if (strobe_s) begin
        pio_writedata_r <= {{(32-LED_W){1'b0}}, strobe_data_s};
      end
    end
  end

  assign pio_address    = 2'b00;
  assign pio_chipselect = pio_chipselect_r;
  assign pio_write_n    = pio_write_n_r;
  assign pio_writedata  = pio_writedata_r;

`ifdef LED_SEQ_IRQ_EN
  logic irq_en_r, done_r, irq_r, done_nx_s, irq_en_nx_s;

  // A DONE set wins over a clear written in the same cycle.
  assign done_nx_s   = done_set_s ? 1'b1 :
                       ((wr_ctrl_s && writedata[5]) ? 1'b0 : done_r);
  assign irq_en_nx_s = wr_ctrl_s ? writedata[4] : irq_en_r;

  // Interrupt enable, DONE flag and registered irq output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_r <= 1'b0;
      done_r   <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      irq_en_r <= irq_en_nx_s;
      done_r   <= done_nx_s;
      irq_r    <= done_nx_s & irq_en_nx_s;
    end
  end

  assign irq      = irq_r;
  assign unused_s = ^{writedata[31:PERIOD_W]};
`else
  assign unused_s = ^{writedata[31:PERIOD_W], done_set_s};
`endif

  // Slave read mux.
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: begin
        readdata[0] = running_s;
        readdata[1] = oneshot_r;
        readdata[2] = (state_r == ST_SHOW_B);
        readdata[3] = pio_chipselect_r;
`ifdef LED_SEQ_IRQ_EN
        readdata[4] = irq_en_r;
        readdata[5] = done_r;
`endif
      end
      2'd1:    readdata[LED_W-1:0]    = pat_a_r;
      2'd2:    readdata[LED_W-1:0]    = pat_b_r;
      2'd3:    readdata[PERIOD_W-1:0] = period_r;
      default: readdata               = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_led_pio_sequencer.sv
module tb_led_pio_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
`ifdef LED_SEQ_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pio_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address        (address),
    .chipselect     (chipselect),
    .write_n        (write_n),
    .writedata      (writedata),
    .readdata       (readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata)
`ifdef LED_SEQ_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  task automatic exp_strobe(input string name, input logic v, input logic [7:0] d);
    chk(name, {28'd0, pio_write_n, pio_chipselect, pio_address}, {28'd0, ~v, v, 2'b00});
    if (v) chk({name, "_data"}, pio_writedata, {24'd0, d});
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;

  vec_t tbl[7];

  // reference model state for the random phase
  bit       m_run, m_phase, m_oneshot, m_irq_en, m_done, m_pend;
  bit [7:0] m_pat[2];
  int       m_period, m_pstart, now;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      2'd0: begin
        v[0] = m_run; v[1] = m_oneshot; v[2] = m_run & m_phase; v[3] = m_pend;
`ifdef LED_SEQ_IRQ_EN
        v[4] = m_irq_en; v[5] = m_done;
`endif
      end
      2'd1: v[7:0] = m_pat[0];
      2'd2: v[7:0] = m_pat[1];
      default: v = 32'(m_period);
    endcase
    return v;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ctrl_3e, ctrl_done_only;
    bit          cs, wn, wrq, nv, set_done;
    bit [7:0]    nd;
    bit [7:0]    newpat[2];
    logic [1:0]  a;
    logic [31:0] d;
    int          r;

`ifdef LED_SEQ_IRQ_EN
    ctrl_3e = 32'h12; ctrl_done_only = 32'h22;
`else
    ctrl_3e = 32'h02; ctrl_done_only = 32'h02;
`endif
    tbl[0] = '{2'd1, 32'hFFFF_FF55, 32'h0000_0055};
    tbl[1] = '{2'd2, 32'h1234_56AA, 32'h0000_00AA};
    tbl[2] = '{2'd3, 32'hFF00_0004, 32'h0000_0004};
    tbl[3] = '{2'd3, 32'hFFFF_FFFF, 32'h00FF_FFFF};
    tbl[4] = '{2'd0, 32'h0000_003E, ctrl_3e};
    tbl[5] = '{2'd0, 32'h0000_0000, 32'h0000_0000};
    tbl[6] = '{2'd3, 32'h0000_0004, 32'h0000_0004};

    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'd0;
    reset_n = 1'b0;
    repeat (3) step();

    // reset state
    exp_strobe("reset_pio", 1'b0, 8'h00);
    chk("reset_wdata", pio_writedata, 32'd0);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("reset_reg%0d", i), 2'(i), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    step();
    exp_strobe("post_reset_no_strobe", 1'b0, 8'h00);

    // register write/readback table
    for (int i = 0; i < 7; i++) begin
      wr(tbl[i].addr, tbl[i].wdata);
      exp_strobe($sformatf("table%0d_no_strobe", i), 1'b0, 8'h00);
      rd_chk($sformatf("table%0d_read", i), tbl[i].addr, tbl[i].rexp);
    end
    // chipselect low must not write
    chipselect = 1'b0; write_n = 1'b0; address = 2'd1; writedata = 32'h99;
    step();
    write_n = 1'b1;
    rd_chk("no_cs_no_write", 2'd1, 32'h55);

    // free-running: strobes at N+1, N+5, N+9
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      exp_strobe($sformatf("run_c%0d", k), (k == 1 || k == 5 || k == 9),
                 (k == 5) ? 8'hAA : 8'h55);
      if (k == 5) rd_chk("run_ctrl_phase_b", 2'd0, 32'h0D);
      step();
    end
    wr(2'd0, 32'h20);
    exp_strobe("stop_strobe", 1'b1, 8'h00);
    rd_chk("stop_ctrl", 2'd0, 32'h08);
    step();
    exp_strobe("stop_after", 1'b0, 8'h00);

    // one-shot: 0x55, 0xAA, 0x00, then silence
    wr(2'd0, 32'h3);
    for (int k = 1; k <= 30; k++) begin
      exp_strobe($sformatf("oneshot_c%0d", k), (k == 1 || k == 5 || k == 9),
                 (k == 1) ? 8'h55 : ((k == 5) ? 8'hAA : 8'h00));
      if (k == 10) rd_chk("oneshot_ctrl_end", 2'd0, ctrl_done_only);
      step();
    end
    wr(2'd0, 32'h20);
    exp_strobe("oneshot_clear_no_strobe", 1'b0, 8'h00);

    // PERIOD=0: a single strobe and then hold
    wr(2'd3, 32'h0);
    wr(2'd0, 32'h1);
    exp_strobe("p0_first", 1'b1, 8'h55);
    for (int k = 0; k < 100; k++) begin
      step();
      exp_strobe($sformatf("p0_hold%0d", k), 1'b0, 8'h00);
    end
    rd_chk("p0_ctrl", 2'd0, 32'h01);
    wr(2'd0, 32'h0);
    exp_strobe("p0_stop", 1'b1, 8'h00);

    // live refresh, refresh on expiry, stop on expiry
    wr(2'd3, 32'h4);
    wr(2'd0, 32'h1);
    exp_strobe("live_start", 1'b1, 8'h55);
    wr(2'd1, 32'h0F);
    exp_strobe("live_refresh", 1'b1, 8'h0F);
    step();
    exp_strobe("live_n3", 1'b0, 8'h00);
    step();
    exp_strobe("live_n4", 1'b0, 8'h00);
    wr(2'd1, 32'h33);
    exp_strobe("expiry_beats_refresh", 1'b1, 8'hAA);
    step();
    exp_strobe("live_n6", 1'b0, 8'h00);
    rd_chk("live_pat_a", 2'd1, 32'h33);
    step();
    step();
    wr(2'd0, 32'h0);
    exp_strobe("stop_beats_expiry", 1'b1, 8'h00);
    rd_chk("stop_expiry_ctrl", 2'd0, 32'h08);

    // asynchronous reset while a strobe is on the bus
    wr(2'd0, 32'h1);
    exp_strobe("pre_reset_strobe", 1'b1, 8'h33);
    #2 reset_n = 1'b0;
    #1;
    exp_strobe("async_reset_pio", 1'b0, 8'h00);
    chk("async_reset_wdata", pio_writedata, 32'd0);
    rd_chk("async_reset_ctrl", 2'd0, 32'd0);
    rd_chk("async_reset_pat_a", 2'd1, 32'd0);
    step();
    @(negedge clk) reset_n = 1'b1;
    step();
    exp_strobe("release_no_strobe", 1'b0, 8'h00);
    step();
    exp_strobe("release_no_strobe2", 1'b0, 8'h00);
    rd_chk("release_ctrl", 2'd0, 32'd0);

`ifdef LED_SEQ_IRQ_EN
    // irq: rises after first B expiry, clear, re-set, set beats clear
    wr(2'd1, 32'h55); wr(2'd2, 32'hAA); wr(2'd3, 32'h2);
    wr(2'd0, 32'h11);
    chk("irq_n1", irq, 1'b0);
    step(); step(); step();
    chk("irq_n4", irq, 1'b0);
    step();
    chk("irq_n5_rise", irq, 1'b1);
    rd_chk("irq_ctrl", 2'd0, 32'h39);
    wr(2'd0, 32'h31);
    chk("irq_cleared", irq, 1'b0);
    step(); step();
    chk("irq_n8", irq, 1'b0);
    step();
    chk("irq_n9_rise", irq, 1'b1);
    step(); step(); step();
    wr(2'd0, 32'h31);
    chk("irq_set_beats_clear", irq, 1'b1);
    wr(2'd0, 32'h20);
    chk("irq_stop_clear", irq, 1'b0);
    exp_strobe("irq_stop_strobe", 1'b1, 8'h00);
`endif

    // randomized run against the reference model
    reset_n = 1'b0;
    step();
    @(negedge clk) reset_n = 1'b1;
    step();
    m_run = 0; m_phase = 0; m_oneshot = 0; m_irq_en = 0; m_done = 0; m_pend = 0;
    m_pat[0] = 8'h00; m_pat[1] = 8'h00; m_period = 0; m_pstart = 0; now = 0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      cs = 0; wn = 1;
      if (r < 25) begin
        cs = 1; wn = 0;
        if (a == 2'd0) begin
          d = d & 32'h3F;
          if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
        end
        if (a == 2'd3) d = (d & 32'hFF00_0000) | 32'($urandom_range(0, 6));
      end else if (r < 30) begin
        cs = 1; wn = 1;
      end else if (r < 35) begin
        cs = 0; wn = 0;
      end
      chipselect = cs; write_n = wn; address = a; writedata = d;
      #1;
      chk("rand_read", readdata, model_read(a));

      wrq = cs && !wn;
      newpat = m_pat;
      if (wrq && a == 2'd1) newpat[0] = d[7:0];
      if (wrq && a == 2'd2) newpat[1] = d[7:0];
      nv = 0; nd = 8'h00; set_done = 0;
      if (!m_run) begin
        if (wrq && a == 2'd0 && d[0]) begin
          m_run = 1; m_phase = 0; m_pstart = now + 1; nv = 1; nd = m_pat[0];
        end
      end else if (wrq && a == 2'd0 && !d[0]) begin
        m_run = 0; m_phase = 0; nv = 1; nd = 8'h00;
      end else if (m_period != 0 && (now - m_pstart) >= m_period - 1) begin
        m_pstart = now + 1; nv = 1;
        if (!m_phase) begin
          m_phase = 1; nd = newpat[1];
        end else begin
          set_done = 1;
          m_phase = 0;
          if (m_oneshot) begin
            m_run = 0; nd = 8'h00;
          end else begin
            nd = newpat[0];
          end
        end
      end else begin
        if (m_period == 0) m_pstart = now + 1;
        if (wrq && int'(a) == int'(m_phase) + 1) begin
          nv = 1; nd = d[7:0];
        end
      end
      if (wrq && a == 2'd0) begin
        m_oneshot = d[1]; m_irq_en = d[4];
        if (d[5]) m_done = 0;
      end
      if (wrq && a == 2'd3) m_period = int'(d[23:0]);
      m_pat = newpat;
      if (set_done) m_done = 1;
      m_pend = nv;

      step();
      exp_strobe("rand_strobe", nv, nd);
`ifdef LED_SEQ_IRQ_EN
      chk("rand_irq", irq, m_done & m_irq_en);
`endif
      now++;
    end
    chipselect = 1'b0; write_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
